// File: rtl/chnl_tx_arbiter.sv
// Round-robin arbiter that multiplexes several requesters onto one RIFFA-style TX channel.
// Each granted requester owns the channel for one whole transaction (START, DATA, DONE).
module chnl_tx_arbiter #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_NUM_REQ        = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [C_NUM_REQ-1:0]                  REQ,
  input  logic [32*C_NUM_REQ-1:0]               REQ_LEN,
  input  logic [C_PCI_DATA_WIDTH*C_NUM_REQ-1:0] REQ_DATA,
  input  logic [C_NUM_REQ-1:0]                  REQ_DATA_VALID,
  output logic [C_NUM_REQ-1:0]                  REQ_DATA_REN,
  output logic [C_NUM_REQ-1:0]                  GNT,
  output logic [C_NUM_REQ-1:0]                  REQ_DONE,
  output logic                                  CHNL_TX_CLK,
  output logic                                  CHNL_TX,
  input  logic                                  CHNL_TX_ACK,
  output logic                                  CHNL_TX_LAST,
  output logic [31:0]                           CHNL_TX_LEN,
  output logic [30:0]                           CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]           CHNL_TX_DATA,
  output logic                                  CHNL_TX_DATA_VALID,
  input  logic                                  CHNL_TX_DATA_REN
);

  localparam int             IW         = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam logic [32:0]    BEAT_WORDS = 33'(C_PCI_DATA_WIDTH / 32);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(C_NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [IW-1:0]          sel_r;
  logic [IW-1:0]          last_winner_r;
  logic [31:0]            len_r;
  logic [32:0]            count_r;
  logic [C_NUM_REQ-1:0]   gnt_r;
  logic [C_NUM_REQ-1:0]   done_r;
  logic                   tx_r;

  logic [IW-1:0]          winner_s;
  logic                   win_found_s;
  logic [C_NUM_REQ-1:0]   win_onehot_s;
  logic [C_NUM_REQ-1:0]   sel_onehot_s;
  logic                   valid_s;
  logic                   beat_s;
  logic [32:0]            count_next_s;
  logic                   last_beat_s;

  // Round-robin search: descending loop so the smallest offset from last_winner wins.
  always_comb begin
    logic [IW:0] cand;
    cand        = {(IW+1){1'b0}};
    winner_s    = last_winner_r;
    win_found_s = 1'b0;
    for (int k = C_NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_winner_r} + (IW+1)'(k);
      if (cand >= (IW+1)'(C_NUM_REQ)) begin
        cand = cand - (IW+1)'(C_NUM_REQ);
      end else begin
        cand = cand;
      end
      if (REQ[cand[IW-1:0]]) begin
        winner_s    = cand[IW-1:0];
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot decodes of the arbitration winner and the latched owner.
  always_comb begin
    win_onehot_s = {C_NUM_REQ{1'b0}};
    sel_onehot_s = {C_NUM_REQ{1'b0}};
    for (int i = 0; i < C_NUM_REQ; i++) begin
      win_onehot_s[i] = (winner_s == IW'(i));
      sel_onehot_s[i] = (sel_r == IW'(i));
    end
  end

  assign valid_s      = (state_r == DATA) && REQ_DATA_VALID[sel_r];
  assign beat_s       = valid_s && CHNL_TX_DATA_REN;
  // Counter runs at 33 bits so a length near 2^32 cannot wrap before the compare.
  assign count_next_s = count_r + BEAT_WORDS;
  assign last_beat_s  = (count_next_s >= {1'b0, len_r});

  // Transaction FSM with registered grant, channel-active and done outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= IDLE;
      sel_r         <= {IW{1'b0}};
      last_winner_r <= LAST_IDX;
      len_r         <= 32'd0;
      count_r       <= 33'd0;
      gnt_r         <= {C_NUM_REQ{1'b0}};
      done_r        <= {C_NUM_REQ{1'b0}};
      tx_r          <= 1'b0;
    end else begin
      done_r <= {C_NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            sel_r   <= winner_s;
            len_r   <= REQ_LEN[32*winner_s +: 32];
            gnt_r   <= win_onehot_s;
            tx_r    <= 1'b1;
            state_r <= START;
          end
        end
        START: begin
          if (CHNL_TX_ACK) begin
            count_r <= 33'd0;
            if (len_r != 32'd0) begin
              state_r <= DATA;
            end else begin
              state_r <= DONE;
              tx_r    <= 1'b0;
              gnt_r   <= {C_NUM_REQ{1'b0}};
              done_r  <= sel_onehot_s;
            end
          end
        end
        DATA: begin
          if (beat_s) begin
            count_r <= count_next_s;
            if (last_beat_s) begin
              state_r <= DONE;
              tx_r    <= 1'b0;
              gnt_r   <= {C_NUM_REQ{1'b0}};
              done_r  <= sel_onehot_s;
            end
          end
        end
        DONE: begin
          last_winner_r <= sel_r;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b0;
          gnt_r   <= {C_NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // Data-phase strobe goes back only to the owner, and only on real beats.
  always_comb begin
    if (beat_s) begin
      REQ_DATA_REN = sel_onehot_s;
    end else begin
      REQ_DATA_REN = {C_NUM_REQ{1'b0}};
    end
  end

  assign GNT                = gnt_r;
  assign REQ_DONE           = done_r;
  assign CHNL_TX_CLK        = CLK;
  assign CHNL_TX            = tx_r;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_LEN        = len_r;
  assign CHNL_TX_OFF        = 31'd0;
  assign CHNL_TX_DATA       = REQ_DATA[C_PCI_DATA_WIDTH*sel_r +: C_PCI_DATA_WIDTH];
  assign CHNL_TX_DATA_VALID = valid_s;

endmodule

// File: tb/tb_chnl_tx_arbiter.sv
// Bench for chnl_tx_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_chnl_tx_arbiter;

  localparam int W    = 128;
  localparam int N    = 4;
  localparam longint BEAT = W / 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [32*N-1:0] req_len;
  logic [W*N-1:0] req_data;
  logic [N-1:0]   req_data_valid;
  logic [N-1:0]   req_data_ren;
  logic [N-1:0]   gnt;
  logic [N-1:0]   req_done;
  logic           tx_clk;
  logic           tx;
  logic           ack;
  logic           tx_last;
  logic [31:0]    tx_len;
  logic [30:0]    tx_off;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           host_ren;

  chnl_tx_arbiter #(.C_PCI_DATA_WIDTH(W), .C_NUM_REQ(N)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_LEN(req_len), .REQ_DATA(req_data),
    .REQ_DATA_VALID(req_data_valid), .REQ_DATA_REN(req_data_ren), .GNT(gnt),
    .REQ_DONE(req_done), .CHNL_TX_CLK(tx_clk), .CHNL_TX(tx), .CHNL_TX_ACK(ack),
    .CHNL_TX_LAST(tx_last), .CHNL_TX_LEN(tx_len), .CHNL_TX_OFF(tx_off),
    .CHNL_TX_DATA(tx_data), .CHNL_TX_DATA_VALID(tx_valid), .CHNL_TX_DATA_REN(host_ren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Transaction-level model: phase 0 idle, 1 waiting for ack, 2 transferring, 3 finished.
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_last  = N - 1;
  logic [31:0] m_len   = 32'd0;
  longint      m_left  = 0;

  // Observations of the DUT, cleared per scenario.
  int beats, done_cnt, ren3_hits, low_run, xfer_k, mode;
  bit seen_high;
  logic prev_tx;
  logic [N-1:0] prev_gnt, prev_done;
  int grant_q[$];
  int done_q[$];
  int gap_q[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_step();
    bit found;
    int idx;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_len = 32'd0; m_left = 0;
    end else begin
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && req[idx]) begin
              found   = 1'b1;
              m_owner = idx;
              m_len   = req_len[32*idx +: 32];
              m_left  = (longint'(m_len) + BEAT - 1) / BEAT;
              m_phase = 1;
            end
          end
        end
        1: if (ack) m_phase = (m_left == 0) ? 3 : 2;
        2: if (req_data_valid[m_owner] && host_ren) begin
             m_left--;
             if (m_left == 0) m_phase = 3;
           end
        default: begin m_last = m_owner; m_phase = 0; end
      endcase
    end
  endtask

  task automatic compare();
    logic act, ev;
    logic [N-1:0] oh, eg, er, ed;
    act = (m_phase == 1) || (m_phase == 2);
    oh  = N'(1 << m_owner);
    eg  = act ? oh : '0;
    ev  = (m_phase == 2) && req_data_valid[m_owner];
    er  = (ev && host_ren) ? oh : '0;
    ed  = (m_phase == 3) ? oh : '0;
    check("gnt",          128'(gnt),          128'(eg));
    check("chnl_tx",      128'(tx),           128'(act));
    check("chnl_tx_len",  128'(tx_len),       128'(m_len));
    check("data_valid",   128'(tx_valid),     128'(ev));
    check("req_data_ren", 128'(req_data_ren), 128'(er));
    check("req_done",     128'(req_done),     128'(ed));
    check("tx_last",      128'(tx_last),      128'(1));
    check("tx_off",       128'(tx_off),       128'(0));
    if (ev) check("tx_data", 128'(tx_data), 128'(req_data[W*m_owner +: W]));
    if (req_data_ren != '0) beats++;
    if (req_data_ren[3]) ren3_hits++;
    if (req_done != '0) begin done_cnt++; done_q.push_back(oh_idx(req_done)); end
    if (gnt != '0 && prev_gnt == '0) grant_q.push_back(oh_idx(gnt));
    if (tx) begin
      if (!prev_tx && seen_high) gap_q.push_back(low_run);
      seen_high = 1'b1;
      low_run   = 0;
    end else begin
      low_run++;
    end
    prev_tx = tx; prev_gnt = gnt; prev_done = req_done;
  endtask

  task automatic drive();
    logic [4:0] pat;
    pat = 5'b11001;
    case (mode)
      0: begin host_ren = 1'b1; req_data_valid = '1; ack = 1'b1; end
      1: begin
        ack = 1'b1;
        host_ren = pat[4 - (xfer_k % 5)];
        req_data_valid = (xfer_k == 3 || xfer_k == 4) ? '0 : '1;
      end
      2: begin
        ack = 1'b1; host_ren = 1'b1;
        req_data_valid = {1'($urandom_range(0, 1)), 3'b111};
        if (m_phase != 0) begin
          req_len[127:96] = $urandom();
          req_len[63:32]  = $urandom();
        end
      end
      3: begin
        rst = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < N; i++) begin
          req[i] = ($urandom_range(0, 9) < 3);
          req_len[32*i +: 32] = 32'($urandom_range(0, 20));
        end
        req_data_valid = N'($urandom());
        host_ren = 1'($urandom_range(0, 1));
        ack      = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    for (int i = 0; i < W * N / 32; i++) req_data[32*i +: 32] = $urandom();
    drive();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    if (m_phase == 2) xfer_k++; else xfer_k = 0;
    #1;
  endtask

  task automatic clear_obs();
    beats = 0; done_cnt = 0; ren3_hits = 0; low_run = 0; seen_high = 1'b0;
    grant_q.delete(); done_q.delete(); gap_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic run_to_idle(input string nm, input int maxc);
    int n = 0;
    while (m_phase != 0 && n < maxc) begin cycle(); n++; end
    check(nm, 128'(m_phase == 0), 128'(1));
  endtask

  task automatic issue(input int who, input logic [31:0] len);
    req_len[32*who +: 32] = len;
    req = N'(1 << who);
    cycle();
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_len = '0; req_data = '0; req_data_valid = '0;
    ack = 1'b0; host_ren = 1'b0; mode = 0; xfer_k = 0;
    prev_tx = 1'b0; prev_gnt = '0; prev_done = '0;
    clear_obs();
    @(posedge clk); model_step(); #1;
    apply_reset();
    check("rst_gnt", 128'(gnt), 128'(0));
    check("rst_len", 128'(tx_len), 128'(0));
    check("rst_tx",  128'(tx), 128'(0));

    // Single request on requester 2, 8 words.
    clear_obs(); mode = 0;
    issue(2, 32'd8);
    check("t1_len", 128'(tx_len), 128'(8));
    run_to_idle("t1_timeout", 40);
    check("t1_beats", 128'(beats), 128'(2));
    check("t1_done_cnt", 128'(done_cnt), 128'(1));
    check("t1_grant", 128'(grant_q.size() > 0 ? grant_q[0] : -1), 128'(2));

    // Contention from all requesters after a fresh reset.
    apply_reset(); clear_obs(); mode = 0;
    for (int i = 0; i < N; i++) req_len[32*i +: 32] = 32'd4;
    req = '1;
    for (int n = 0; n < 200 && grant_q.size() < 5; n++) cycle();
    req = '0;
    run_to_idle("t2_timeout", 40);
    check("t2_grants", 128'(grant_q.size()), 128'(5));
    for (int i = 0; i < 5 && i < grant_q.size(); i++) check("t2_order", 128'(grant_q[i]), 128'(i % N));
    for (int i = 0; i < 4 && i < done_q.size(); i++) check("t2_done_order", 128'(done_q[i]), 128'(i));
    check("t2_gaps", 128'(gap_q.size()), 128'(4));
    for (int i = 0; i < gap_q.size(); i++) check("t2_gap_len", 128'(gap_q[i]), 128'(2));

    // Zero-length transaction.
    clear_obs(); mode = 0;
    issue(0, 32'd0);
    run_to_idle("t3_timeout", 20);
    check("t3_beats", 128'(beats), 128'(0));
    check("t3_done_cnt", 128'(done_cnt), 128'(1));
    check("t3_done_who", 128'(done_q.size() > 0 ? done_q[0] : -1), 128'(0));

    // Backpressure on both sides.
    clear_obs(); mode = 1;
    issue(0, 32'd12);
    run_to_idle("t4_timeout", 40);
    check("t4_beats", 128'(beats), 128'(3));
    check("t4_done_cnt", 128'(done_cnt), 128'(1));

    // Rounding with a noisy neighbour.
    clear_obs(); mode = 2;
    issue(1, 32'd6);
    run_to_idle("t5_timeout", 40);
    check("t5_beats", 128'(beats), 128'(2));
    check("t5_ren3", 128'(ren3_hits), 128'(0));

    // Reset in the middle of the data phase.
    clear_obs(); mode = 0;
    issue(0, 32'd16);
    for (int n = 0; n < 20 && beats < 1; n++) cycle();
    mode = 4; host_ren = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t6_tx_after_rst", 128'(tx), 128'(0));
    check("t6_gnt_after_rst", 128'(gnt), 128'(0));
    cycle();
    check("t6_no_done", 128'(done_cnt), 128'(0));
    check("t6_beats_before", 128'(beats), 128'(1));
    clear_obs(); mode = 0;
    issue(1, 32'd8);
    run_to_idle("t6_timeout", 40);
    check("t6_fresh_beats", 128'(beats), 128'(2));
    check("t6_fresh_done", 128'(done_q.size() > 0 ? done_q[0] : -1), 128'(1));

    // Randomized traffic with occasional reset.
    clear_obs(); mode = 3;
    for (int n = 0; n < 1500; n++) cycle();
    mode = 4; rst = 1'b0; req = '0; ack = 1'b1; host_ren = 1'b1; req_data_valid = '1;
    run_to_idle("t7_drain", 200);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
